// File: rtl/qf_rwhwsc_bank.sv
// qf_rwhwsc_bank: bank of software/hardware-writable control/status registers.
// Each register mixes plain RW bits and write-1-to-clear status bits. Hardware can
// overwrite a whole register or set individual bits; a collision counter tracks
// same-register SW/HW write clashes; irq is the registered OR of all set W1C bits.
//
// Read handshake: rd_en is sampled every cycle with no back-pressure. A read issued
// in cycle N returns rddata/rd_err with a single-cycle rd_valid pulse in cycle N+1.
// rddata/rd_err hold their last values while rd_valid is low. Reads return the
// register contents from before any same-cycle write.
module qf_rwhwsc_bank #(
  parameter int PAR_NUM_REG    = 4,
  parameter int PAR_BIT_WIDTH  = 16,
  parameter int PAR_ADDR_WIDTH = 2,
  parameter logic [PAR_NUM_REG*PAR_BIT_WIDTH-1:0] PAR_DEFAULT_VALUE = '0,
  parameter logic [PAR_NUM_REG*PAR_BIT_WIDTH-1:0] PAR_W1C_MASK      = '0,
  parameter bit PAR_HW_PRIO = 1'b1
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   wr_en,
  input  logic [PAR_ADDR_WIDTH-1:0]              wr_addr,
  input  logic [PAR_BIT_WIDTH-1:0]               wrdata,
  input  logic                                   rd_en,
  input  logic [PAR_ADDR_WIDTH-1:0]              rd_addr,
  output logic [PAR_BIT_WIDTH-1:0]               rddata,
  output logic                                   rd_valid,
  output logic                                   rd_err,
  input  logic [PAR_NUM_REG-1:0]                 hw_wr_en,
  input  logic [PAR_NUM_REG*PAR_BIT_WIDTH-1:0]   hw_wrdata,
  input  logic [PAR_NUM_REG*PAR_BIT_WIDTH-1:0]   hw_set,
  output logic [PAR_NUM_REG*PAR_BIT_WIDTH-1:0]   reg_q,
  input  logic                                   coll_clr,
  output logic [7:0]                             coll_cnt,
  output logic                                   irq
);

  localparam int N = PAR_NUM_REG;
  localparam int W = PAR_BIT_WIDTH;

  logic [N*W-1:0] reg_q_q, reg_d;
  logic [W-1:0]   rddata_q, rddata_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_err_q, rd_err_d;
  logic [7:0]     coll_cnt_q, coll_cnt_d;
  logic           irq_q, irq_d;
  logic           coll_hit;

  // Software write effect: RW bits take the data, W1C bits clear where data is 1.
  function automatic logic [W-1:0] sw_apply(input logic [W-1:0] cur,
                                            input logic [W-1:0] wd,
                                            input logic [W-1:0] msk);
    return (wd & ~msk) | (cur & msk & ~wd);
  endfunction

  // Lower-priority write first, then the winning write, then sticky set pulses,
  // so a losing write vanishes and a set pulse is never lost to a clear.
  function automatic logic [W-1:0] next_val(input logic [W-1:0] cur,
                                            input logic         sw,
                                            input logic         hw,
                                            input logic [W-1:0] wd,
                                            input logic [W-1:0] hwd,
                                            input logic [W-1:0] set,
                                            input logic [W-1:0] msk);
    logic [W-1:0] v;
    v = cur;
    if (PAR_HW_PRIO) begin
      if (sw) v = sw_apply(v, wd, msk);
      if (hw) v = hwd;
    end else begin
      if (hw) v = hwd;
      if (sw) v = sw_apply(v, wd, msk);
    end
    return v | set;
  endfunction

  // Register next-state and collision detection for every register.
  always_comb begin
    reg_d    = reg_q_q;
    coll_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic sw_hit;
      sw_hit = wr_en && (wr_addr == PAR_ADDR_WIDTH'(i));
      reg_d[i*W +: W] = next_val(reg_q_q[i*W +: W], sw_hit, hw_wr_en[i],
                                 wrdata, hw_wrdata[i*W +: W], hw_set[i*W +: W],
                                 PAR_W1C_MASK[i*W +: W]);
      if (sw_hit && hw_wr_en[i]) coll_hit = 1'b1;
    end
  end

  // Collision counter: clear wins over increment, but a clashing cycle counts as one.
  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (coll_clr) begin
      coll_cnt_d = coll_hit ? 8'd1 : 8'd0;
    end else if (coll_hit && (coll_cnt_q != 8'hFF)) begin
      coll_cnt_d = coll_cnt_q + 8'd1;
    end
  end

  // Read port: decode against the pre-write register contents; out-of-range flags rd_err.
  always_comb begin
    rddata_d   = rddata_q;
    rd_err_d   = rd_err_q;
    rd_valid_d = rd_en;
    if (rd_en) begin
      rddata_d = '0;
      rd_err_d = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (rd_addr == PAR_ADDR_WIDTH'(i)) begin
          rddata_d = reg_q_q[i*W +: W];
          rd_err_d = 1'b0;
        end
      end
    end
  end

  // Interrupt request: any W1C bit currently set.
  always_comb begin
    irq_d = |(reg_q_q & PAR_W1C_MASK);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      reg_q_q    <= PAR_DEFAULT_VALUE;
      rddata_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      coll_cnt_q <= 8'd0;
      irq_q      <= 1'b0;
    end else begin
      reg_q_q    <= reg_d;
      rddata_q   <= rddata_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      coll_cnt_q <= coll_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign reg_q    = reg_q_q;
  assign rddata   = rddata_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign coll_cnt = coll_cnt_q;
  assign irq      = irq_q;

endmodule
